elevador_cabina: RTL and testbench
==================================

# elevador_cabina

Behavioural car/shaft model that sits on the far end of the elevator controller's motor interface. It accepts the controller's up/down motor commands, advances a car position counter at a fixed travel rate, and returns floor-level, arrival and limit-switch sensor signals. It also drives the floor number on a 7-segment display. It is used on-chip as the plant for closed-loop demos and as the stimulus responder in controller benches.

## Interface

Parameters:
- NUM_FLOORS, 4: number of floors, legal range 2..10; floors are numbered 0..NUM_FLOORS-1.
- TRAVEL_CYCLES, 1000: clock cycles to move one floor, legal range ≥2.

Ports:
- clk  input  1  system clock; single clock domain, rising edge.
- rst  input  1  synchronous, active-high reset.
- motor_subir  input  1  up command from the controller.
- motor_bajar  input  1  down command from the controller.
- piso  output  4  floor at or directly below the car.
- pos  output  $clog2(TRAVEL_CYCLES)  offset above floor `piso`, in cycles; 0 means level with the floor.
- en_piso  output  1  car is level with floor `piso` (pos==0).
- llegada  output  1  one-cycle pulse when the car becomes level with a floor after moving.
- limite_inf  output  1  car is level with floor 0.
- limite_sup  output  1  car is level with floor NUM_FLOORS-1.
- fallo  output  1  latched fault: both motor commands were seen high together.
- seg  output  7  7-segment pattern, active high, bit order {g,f,e,d,c,b,a}.

## Operation

- All outputs are registered. Reset values: piso=0, pos=0, en_piso=1, llegada=0, limite_inf=1, limite_sup=0, fallo=0, seg=7'h3F.
- States:
  - IDLE: no command active.
  - SUBIENDO: moving up.
  - BAJANDO: moving down.
  - FALLO: fault latched.
- The state is re-evaluated every cycle from the sampled commands. No inertia: a command takes effect on the first edge at which it is sampled.
- Up step, taken when motor_subir=1 and motor_bajar=0:
  - If pos < TRAVEL_CYCLES-1: pos += 1.
  - If pos == TRAVEL_CYCLES-1: pos=0, piso += 1, llegada=1.
  - If at the top floor with pos=0: the command is ignored and nothing changes.
- Down step, taken when motor_bajar=1 and motor_subir=0:
  - If pos > 1: pos -= 1.
  - If pos == 1: pos=0, llegada=1.
  - If pos == 0 and piso > 0: piso -= 1, pos=TRAVEL_CYCLES-1.
  - If at floor 0 with pos=0: the command is ignored.
- A full floor takes exactly TRAVEL_CYCLES commanded cycles in either direction.
- No command: pos and piso hold. The car never drifts.
- Reversal mid-segment: the counter simply steps the other way; there is no penalty or restart.
- llegada is asserted only on the stepping edge that makes pos 0. It is never asserted while idle at a floor or when a limit-switch command is ignored.
- Fault condition: motor_subir=1 and motor_bajar=1 in the same cycle.
  - Next edge: fallo=1 and the state becomes FALLO.
  - piso and pos freeze and all further commands are ignored.
  - FALLO is left only through rst.
  - While in FALLO: seg=7'h71 ("F") and llegada=0.
- Display outside FALLO: seg shows the digit for piso using 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Reset mid-travel: the car returns to floor 0 with pos=0 immediately; no arrival pulse is generated.

## Timing

- Command-to-response latency is one cycle: a command sampled at edge k updates pos, piso, en_piso, llegada, the limit switches and seg at edge k.
- llegada is high for exactly one cycle, coincident with the first cycle of en_piso=1 at the new level.
- The limit switches and en_piso are valid every cycle and are derived from the registered piso and pos values.
- rst has priority over every other input, including a simultaneous fault condition.

## Test plan

Unless stated otherwise, TRAVEL_CYCLES=4 and NUM_FLOORS=4.

1. **Reset.** Hold rst for 2 cycles, then release. Required: piso=0, pos=0, en_piso=1, limite_inf=1, limite_sup=0, llegada=0, fallo=0, seg=3F.
2. **Climb to the top.** Hold motor_subir for 12 cycles. Required:
   - llegada pulses at cycles 4, 8 and 12, each time with en_piso=1.
   - piso steps 1→2→3; seg shows 06, 5B, 4F.
   - After cycle 12: limite_sup=1.
   - Hold motor_subir 5 more cycles: no change and no llegada.
3. **Reversal.** From floor 1 level, assert subir for 2 cycles (pos=2), then bajar for 2 cycles. Required: pos 1, 0; llegada pulses once at pos 0; piso remains 1 throughout.
4. **Descent across a floor.** From floor 2 level, hold bajar for 4 cycles. Required:
   - First edge: piso=1, pos=3, en_piso=0, seg=06.
   - Fourth edge: pos=0 and llegada=1.
5. **Floor-0 limit.** At floor 0, hold bajar for 6 cycles. Required: piso=0, pos=0 and limite_inf=1 throughout; llegada never asserted.
6. **Fault.** Mid-segment with pos=2, assert subir and bajar together for 1 cycle. Required:
   - Next cycle: fallo=1, seg=71.
   - Then apply subir alone for 5 cycles: pos stays 2 and fallo stays 1.
   - Then assert rst: fallo=0, piso=0, pos=0.

Source files
------------

// File: rtl/elevador_cabina.sv
// elevador_cabina: behavioural elevator car/shaft plant.
// Takes up/down motor commands, moves a position counter one step per
// commanded cycle, and returns floor-level, arrival, limit-switch, fault
// and 7-segment outputs. Every output is registered and reflects the
// command sampled on the same edge.
module elevador_cabina #(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             motor_subir,
  input  logic                             motor_bajar,
  output logic [3:0]                       piso,
  output logic [$clog2(TRAVEL_CYCLES)-1:0] pos,
  output logic                             en_piso,
  output logic                             llegada,
  output logic                             limite_inf,
  output logic                             limite_sup,
  output logic                             fallo,
  output logic [6:0]                       seg
);

  localparam int PW = $clog2(TRAVEL_CYCLES);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SUBIENDO = 2'd1;
  localparam logic [1:0] S_BAJANDO  = 2'd2;
  localparam logic [1:0] S_FALLO    = 2'd3;

  localparam logic [3:0]    TOP   = 4'(NUM_FLOORS - 1);
  localparam logic [PW-1:0] P_MAX = PW'(TRAVEL_CYCLES - 1);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [6:0]    SEG_F = 7'h71;

  logic [1:0]    state, state_n;
  logic [3:0]    piso_n;
  logic [PW-1:0] pos_n;
  logic          lleg_n;
  logic          nivel_n;

  // Digit patterns, active high, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] digito(input logic [3:0] d);
    case (d)
      4'd0:    digito = 7'h3F;
      4'd1:    digito = 7'h06;
      4'd2:    digito = 7'h5B;
      4'd3:    digito = 7'h4F;
      4'd4:    digito = 7'h66;
      4'd5:    digito = 7'h6D;
      4'd6:    digito = 7'h7D;
      4'd7:    digito = 7'h07;
      4'd8:    digito = 7'h7F;
      4'd9:    digito = 7'h6F;
      default: digito = 7'h00;
    endcase
  endfunction

  // Next state and next car position from the commands sampled this cycle.
  always_comb begin
    state_n = state;
    piso_n  = piso;
    pos_n   = pos;
    lleg_n  = 1'b0;
    if (state != S_FALLO) begin
      if (motor_subir && motor_bajar) begin
        // Conflicting commands: latch the fault, car freezes where it is.
        state_n = S_FALLO;
      end else if (motor_subir) begin
        state_n = S_SUBIENDO;
        if (pos == P_MAX) begin
          pos_n  = '0;
          piso_n = piso + 4'd1;
          lleg_n = 1'b1;
        end else if (!(piso == TOP && pos == '0)) begin
          pos_n = pos + P_ONE;
        end
      end else if (motor_bajar) begin
        state_n = S_BAJANDO;
        if (pos > P_ONE) begin
          pos_n = pos - P_ONE;
        end else if (pos == P_ONE) begin
          pos_n  = '0;
          lleg_n = 1'b1;
        end else if (piso != 4'd0) begin
          // Leaving a level downwards drops straight into the segment below.
          piso_n = piso - 4'd1;
          pos_n  = P_MAX;
        end
      end else begin
        state_n = S_IDLE;
      end
    end
  end

  assign nivel_n = (pos_n == '0);

  // Register state, position and all sensor/display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      piso       <= 4'd0;
      pos        <= '0;
      en_piso    <= 1'b1;
      llegada    <= 1'b0;
      limite_inf <= 1'b1;
      limite_sup <= 1'b0;
      fallo      <= 1'b0;
      seg        <= 7'h3F;
    end else begin
      state      <= state_n;
      piso       <= piso_n;
      pos        <= pos_n;
      en_piso    <= nivel_n;
      llegada    <= lleg_n;
      limite_inf <= nivel_n && (piso_n == 4'd0);
      limite_sup <= nivel_n && (piso_n == TOP);
      fallo      <= (state_n == S_FALLO);
      seg        <= (state_n == S_FALLO) ? SEG_F : digito(piso_n);
    end
  end

endmodule

// File: tb/tb_elevador_cabina.sv
// Directed bench for elevador_cabina with TRAVEL_CYCLES=4, NUM_FLOORS=4.
module tb_elevador_cabina;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       motor_subir = 1'b0;
  logic       motor_bajar = 1'b0;
  logic [3:0] piso;
  logic [1:0] pos;
  logic       en_piso, llegada, limite_inf, limite_sup, fallo;
  logic [6:0] seg;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] digits [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  elevador_cabina #(.NUM_FLOORS(4), .TRAVEL_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .motor_subir(motor_subir), .motor_bajar(motor_bajar),
    .piso(piso), .pos(pos), .en_piso(en_piso), .llegada(llegada),
    .limite_inf(limite_inf), .limite_sup(limite_sup), .fallo(fallo), .seg(seg)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic s, input logic b, input int n);
    motor_subir = s;
    motor_bajar = b;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd(1'b0, 1'b0, 2);
    rst = 1'b0;
    step();
    vectors++;
    if ({piso, pos, en_piso, limite_inf, limite_sup, llegada, fallo, seg} !==
        {4'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h3F}) begin
      miscompares++;
      $display("FAIL reset: piso=%0d pos=%0d en=%b inf=%b sup=%b lleg=%b fallo=%b seg=%h, want 0 0 1 1 0 0 0 3f",
               piso, pos, en_piso, limite_inf, limite_sup, llegada, fallo, seg);
    end
  endtask

  task automatic test_climb();
    motor_subir = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      logic [3:0] ep;
      logic [1:0] eq;
      logic       lv;
      step();
      ep = 4'(i / 4);
      eq = 2'(i % 4);
      lv = (eq == 2'd0);
      vectors++;
      if ({piso, pos, llegada, en_piso, seg, limite_sup} !==
          {ep, eq, lv, lv, digits[ep], lv && ep == 4'd3}) begin
        miscompares++;
        $display("FAIL climb[%0d]: piso=%0d pos=%0d lleg=%b en=%b seg=%h sup=%b, want %0d %0d %b %b %h %b",
                 i, piso, pos, llegada, en_piso, seg, limite_sup,
                 ep, eq, lv, lv, digits[ep], lv && ep == 4'd3);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({piso, pos, llegada, limite_sup, seg} !== {4'd3, 2'd0, 1'b0, 1'b1, 7'h4F}) begin
        miscompares++;
        $display("FAIL top_hold[%0d]: piso=%0d pos=%0d lleg=%b sup=%b seg=%h, want 3 0 0 1 4f",
                 i, piso, pos, llegada, limite_sup, seg);
      end
    end
    motor_subir = 1'b0;
  endtask

  task automatic test_reversal();
    // From floor 3 level, 8 down cycles reach floor 1 level.
    cmd(1'b0, 1'b1, 8);
    vectors++;
    if ({piso, pos, limite_sup, seg} !== {4'd1, 2'd0, 1'b0, 7'h06}) begin
      miscompares++;
      $display("FAIL reach_f1: piso=%0d pos=%0d sup=%b seg=%h, want 1 0 0 06", piso, pos, limite_sup, seg);
    end
    cmd(1'b1, 1'b0, 2);
    vectors++;
    if ({piso, pos, en_piso} !== {4'd1, 2'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL rev_up: piso=%0d pos=%0d en=%b, want 1 2 0", piso, pos, en_piso);
    end
    // No command: the car holds mid-segment.
    cmd(1'b0, 1'b0, 3);
    vectors++;
    if ({piso, pos, llegada} !== {4'd1, 2'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL idle_hold: piso=%0d pos=%0d lleg=%b, want 1 2 0", piso, pos, llegada);
    end
    cmd(1'b0, 1'b1, 1);
    vectors++;
    if ({piso, pos, llegada} !== {4'd1, 2'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL rev_dn1: piso=%0d pos=%0d lleg=%b, want 1 1 0", piso, pos, llegada);
    end
    cmd(1'b0, 1'b1, 1);
    vectors++;
    if ({piso, pos, llegada, en_piso} !== {4'd1, 2'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL rev_dn2: piso=%0d pos=%0d lleg=%b en=%b, want 1 0 1 1", piso, pos, llegada, en_piso);
    end
    cmd(1'b0, 1'b0, 1);
    vectors++;
    if ({llegada, en_piso} !== {1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL lleg_one_cycle: lleg=%b en=%b, want 0 1", llegada, en_piso);
    end
  endtask

  task automatic test_descent();
    cmd(1'b1, 1'b0, 4);
    vectors++;
    if ({piso, pos, seg} !== {4'd2, 2'd0, 7'h5B}) begin
      miscompares++;
      $display("FAIL reach_f2: piso=%0d pos=%0d seg=%h, want 2 0 5b", piso, pos, seg);
    end
    cmd(1'b0, 1'b1, 1);
    vectors++;
    if ({piso, pos, en_piso, seg, llegada} !== {4'd1, 2'd3, 1'b0, 7'h06, 1'b0}) begin
      miscompares++;
      $display("FAIL desc_e1: piso=%0d pos=%0d en=%b seg=%h lleg=%b, want 1 3 0 06 0",
               piso, pos, en_piso, seg, llegada);
    end
    cmd(1'b0, 1'b1, 2);
    vectors++;
    if ({piso, pos, llegada} !== {4'd1, 2'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL desc_e3: piso=%0d pos=%0d lleg=%b, want 1 1 0", piso, pos, llegada);
    end
    cmd(1'b0, 1'b1, 1);
    vectors++;
    if ({piso, pos, llegada, en_piso} !== {4'd1, 2'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL desc_e4: piso=%0d pos=%0d lleg=%b en=%b, want 1 0 1 1", piso, pos, llegada, en_piso);
    end
  endtask

  task automatic test_floor0_limit();
    cmd(1'b0, 1'b1, 4);
    vectors++;
    if ({piso, pos, limite_inf, llegada, seg} !== {4'd0, 2'd0, 1'b1, 1'b1, 7'h3F}) begin
      miscompares++;
      $display("FAIL reach_f0: piso=%0d pos=%0d inf=%b lleg=%b seg=%h, want 0 0 1 1 3f",
               piso, pos, limite_inf, llegada, seg);
    end
    motor_bajar = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if ({piso, pos, limite_inf, llegada} !== {4'd0, 2'd0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL f0_hold[%0d]: piso=%0d pos=%0d inf=%b lleg=%b, want 0 0 1 0",
                 i, piso, pos, limite_inf, llegada);
      end
    end
    motor_bajar = 1'b0;
  endtask

  task automatic test_fault();
    cmd(1'b1, 1'b0, 2);
    vectors++;
    if ({piso, pos, fallo} !== {4'd0, 2'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL pre_fault: piso=%0d pos=%0d fallo=%b, want 0 2 0", piso, pos, fallo);
    end
    cmd(1'b1, 1'b1, 1);
    vectors++;
    if ({fallo, seg, pos, piso, llegada, en_piso} !== {1'b1, 7'h71, 2'd2, 4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL fault_set: fallo=%b seg=%h pos=%0d piso=%0d lleg=%b en=%b, want 1 71 2 0 0 0",
               fallo, seg, pos, piso, llegada, en_piso);
    end
    motor_subir = 1'b1;
    motor_bajar = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({pos, piso, fallo, seg, llegada} !== {2'd2, 4'd0, 1'b1, 7'h71, 1'b0}) begin
        miscompares++;
        $display("FAIL fault_frozen[%0d]: pos=%0d piso=%0d fallo=%b seg=%h lleg=%b, want 2 0 1 71 0",
                 i, pos, piso, fallo, seg, llegada);
      end
    end
    motor_subir = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({fallo, piso, pos, seg, en_piso, llegada} !== {1'b0, 4'd0, 2'd0, 7'h3F, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL fault_clear: fallo=%b piso=%0d pos=%0d seg=%h en=%b lleg=%b, want 0 0 0 3f 1 0",
               fallo, piso, pos, seg, en_piso, llegada);
    end
  endtask

  task automatic test_reset_priority();
    // Climb to floor 1, pos 1, then reset together with a fault condition.
    cmd(1'b1, 1'b0, 5);
    vectors++;
    if ({piso, pos} !== {4'd1, 2'd1}) begin
      miscompares++;
      $display("FAIL pre_rst: piso=%0d pos=%0d, want 1 1", piso, pos);
    end
    rst = 1'b1;
    cmd(1'b1, 1'b1, 1);
    rst = 1'b0;
    motor_subir = 1'b0;
    motor_bajar = 1'b0;
    vectors++;
    if ({fallo, piso, pos, llegada, seg, limite_inf} !== {1'b0, 4'd0, 2'd0, 1'b0, 7'h3F, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_priority: fallo=%b piso=%0d pos=%0d lleg=%b seg=%h inf=%b, want 0 0 0 0 3f 1",
               fallo, piso, pos, llegada, seg, limite_inf);
    end
    step();
    vectors++;
    if ({fallo, piso, pos} !== {1'b0, 4'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL post_rst: fallo=%b piso=%0d pos=%0d, want 0 0 0", fallo, piso, pos);
    end
  endtask

  initial begin
    test_reset();
    test_climb();
    test_reversal();
    test_descent();
    test_floor0_limit();
    test_fault();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
